// File: rtl/instr_fetch_rom_pkg.sv
// Shared definitions for the instruction fetch unit: FSM states, default widths
// and the 2-bit opcode set that lives in the instruction word MSBs.
package instr_fetch_rom_pkg;

  localparam int DEF_DATA_W = 17;
  localparam int DEF_ADDR_W = 4;
  localparam int DEF_OP_W   = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

  localparam logic [1:0] OP_HALT = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_ALU  = 2'b10;
  localparam logic [1:0] OP_JUMP = 2'b11;

endpackage

// File: rtl/rom_sync_mem.sv
// Program store: one write port, one synchronous read port with read enable.
// The array powers up zeroed and is never touched by rst; only the read register is.
module rom_sync_mem #(
  parameter int WIDTH  = 17,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [WIDTH-1:0] mem_q [DEPTH] = '{default: {WIDTH{1'b0}}};
  logic [WIDTH-1:0] rdata_q;

  // Write port; no reset so program contents survive rst.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Read register holds its word while re is low, which gives the fetch path backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= {WIDTH{1'b0}};
    end else if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/instr_fetch_rom.sv
// Instruction fetch unit: IDLE/RUN/HALT sequencer over a synchronous program store.
// Define INSTR_FETCH_ROM_PARITY_EN to store an even-parity bit per word and flag fetch errors.
module instr_fetch_rom
  import instr_fetch_rom_pkg::*;
#(
  parameter int                DATA_W    = DEF_DATA_W,
  parameter int                ADDR_W    = DEF_ADDR_W,
  parameter int                OP_W      = DEF_OP_W,
  parameter logic [DATA_W-1:0] HALT_WORD = {DATA_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              jmp_en,
  input  logic [ADDR_W-1:0] jmp_addr,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ready,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  output logic [OP_W-1:0]   opcode,
  output logic              halted,
  output logic              parity_err
);

`ifdef INSTR_FETCH_ROM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;

  function automatic logic even_parity(input logic [DATA_W-1:0] data);
    return ^data;
  endfunction
`else
  localparam int MEM_W = DATA_W;
`endif

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
  logic              valid_q, valid_d;
  logic              mem_we, mem_re;
  logic [MEM_W-1:0]  mem_wdata;
  logic [MEM_W-1:0]  mem_rdata;
  logic              halt_seen;

`ifdef INSTR_FETCH_ROM_PARITY_EN
  assign mem_wdata = {even_parity(ld_data), ld_data};
`else
  assign mem_wdata = ld_data;
`endif

  rom_sync_mem #(
    .WIDTH  (MEM_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (mem_we),
    .waddr (ld_addr),
    .wdata (mem_wdata),
    .re    (mem_re),
    .raddr (pc_q),
    .rdata (mem_rdata)
  );

  assign instr       = mem_rdata[DATA_W-1:0];
  assign instr_pc    = instr_pc_q;
  assign instr_valid = valid_q;
  assign opcode      = instr[DATA_W-1 -: OP_W];
  assign halted      = (state_q == ST_HALT);
  assign halt_seen   = valid_q && (instr == HALT_WORD);

  // Next-state: start beats jump, jump beats halt detection and fetch/accept.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        mem_we = ld_en;
        if (start) begin
          state_d = ST_RUN;
          pc_d    = {ADDR_W{1'b0}};
          valid_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (start) begin
          pc_d    = {ADDR_W{1'b0}};
          valid_d = 1'b0;
        end else if (jmp_en) begin
          pc_d    = jmp_addr;
          valid_d = 1'b0;
        end else if (halt_seen) begin
          // Halt word stays on instr until the consumer takes it; pc is frozen from here.
          state_d = ST_HALT;
          valid_d = ~ready;
        end else if (!valid_q || ready) begin
          mem_re     = 1'b1;
          instr_pc_d = pc_q;
          valid_d    = 1'b1;
          pc_d       = pc_q + ADDR_W'(1'b1);
        end else begin
          valid_d = valid_q;
        end
      end
      ST_HALT: begin
        mem_we = ld_en;
        if (start) begin
          state_d = ST_RUN;
          pc_d    = {ADDR_W{1'b0}};
          valid_d = 1'b0;
        end else if (valid_q && ready) begin
          valid_d = 1'b0;
        end else begin
          valid_d = valid_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        pc_d    = {ADDR_W{1'b0}};
        valid_d = 1'b0;
      end
    endcase
  end

  // Sequencer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pc_q       <= {ADDR_W{1'b0}};
      instr_pc_q <= {ADDR_W{1'b0}};
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
    end
  end

`ifdef INSTR_FETCH_ROM_PARITY_EN
  logic perr_q, perr_d, fetch_bad;

  // A stored word with odd total parity is corrupt; flag it while it is on instr.
  assign fetch_bad = valid_q && (^mem_rdata);

  // Sticky fault, cleared only by start or rst.
  always_comb begin
    perr_d = perr_q;
    if (start) begin
      perr_d = 1'b0;
    end else begin
      perr_d = perr_q | fetch_bad;
    end
  end

  // Parity fault register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perr_q <= 1'b0;
    end else begin
      perr_q <= perr_d;
    end
  end

  assign parity_err = perr_q | fetch_bad;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_rom.sv
// Self-checking bench for instr_fetch_rom: directed scenarios plus a randomized
// ready/jump run checked against a program-order reference model.
module tb_instr_fetch_rom;

  localparam int DW    = 17;
  localparam int AW    = 4;
  localparam int OW    = 2;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst, start, jmp_en, ld_en, ready;
  logic [AW-1:0] jmp_addr, ld_addr;
  logic [DW-1:0] ld_data;
  logic [DW-1:0] instr;
  logic [AW-1:0] instr_pc;
  logic          instr_valid;
  logic [OW-1:0] opcode;
  logic          halted, parity_err;

  int            n_tests = 0;
  int            n_fail  = 0;
  logic [DW-1:0] model_mem [DEPTH];

  instr_fetch_rom #(
    .DATA_W    (DW),
    .ADDR_W    (AW),
    .OP_W      (OW),
    .HALT_WORD ({DW{1'b0}})
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .jmp_en      (jmp_en),
    .jmp_addr    (jmp_addr),
    .ld_en       (ld_en),
    .ld_addr     (ld_addr),
    .ld_data     (ld_data),
    .ready       (ready),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .opcode      (opcode),
    .halted      (halted),
    .parity_err  (parity_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; jmp_en = 1'b0; ld_en = 1'b0; ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic load_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    tick();
    ld_en = 1'b0;
    model_mem[a] = d;
  endtask

  task automatic start_run();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic load_random_program();
    for (int a = 0; a < DEPTH; a++) begin
      load_word(AW'(a), DW'($urandom_range(1, (1 << DW) - 1)));
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; jmp_en = 1'b0; jmp_addr = '0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0; ready = 1'b0;
    #2;
    n_tests++;
    if ({instr, instr_pc, instr_valid, halted, parity_err} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: instr=%h pc=%0d valid=%b halted=%b perr=%b, want all 0",
               instr, instr_pc, instr_valid, halted, parity_err);
    end
    tick();
    rst = 1'b0;
    // Memory is zero from elaboration, so address 0 holds the halt word.
    start_run();
    ready = 1'b1;
    tick();
    n_tests++;
    if (instr_valid !== 1'b1 || instr !== '0 || instr_pc !== '0) begin
      n_fail++;
      $display("FAIL elab_zero: valid=%b instr=%h pc=%0d, want 1/0/0", instr_valid, instr, instr_pc);
    end
    tick();
    n_tests++;
    if (halted !== 1'b1 || instr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_halt: halted=%b valid=%b, want 1/0", halted, instr_valid);
    end
  endtask

  task automatic test_program();
    logic [DW-1:0] prog [4];
    prog[0] = 17'd1; prog[1] = 17'd2; prog[2] = 17'd3; prog[3] = 17'd0;
    do_reset();
    for (int a = 0; a < 4; a++) load_word(AW'(a), prog[a]);
    start_run();
    ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_tests++;
      if (instr_valid !== 1'b1 || instr_pc !== AW'(i) || instr !== prog[i] ||
          opcode !== prog[i][DW-1 -: OW]) begin
        n_fail++;
        $display("FAIL program_seq[%0d]: valid=%b pc=%0d instr=%h op=%b, want 1/%0d/%h/%b",
                 i, instr_valid, instr_pc, instr, opcode, i, prog[i], prog[i][DW-1 -: OW]);
      end
    end
    tick();
    tick();
    n_tests++;
    if (halted !== 1'b1 || instr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL program_halt: halted=%b valid=%b, want 1/0", halted, instr_valid);
    end
    start_run();
    tick();
    n_tests++;
    if (halted !== 1'b0 || instr_valid !== 1'b1 || instr_pc !== '0 || instr !== prog[0]) begin
      n_fail++;
      $display("FAIL restart_from_halt: halted=%b valid=%b pc=%0d instr=%h, want 0/1/0/%h",
               halted, instr_valid, instr_pc, instr, prog[0]);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    load_random_program();
    start_run();
    ready = 1'b1;
    tick(); tick(); tick();
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (instr_valid !== 1'b1 || instr_pc !== 4'd2 || instr !== model_mem[2]) begin
        n_fail++;
        $display("FAIL backpressure_hold[%0d]: valid=%b pc=%0d instr=%h, want 1/2/%h",
                 i, instr_valid, instr_pc, instr, model_mem[2]);
      end
    end
    ready = 1'b1;
    tick();
    n_tests++;
    if (instr_valid !== 1'b1 || instr_pc !== 4'd3 || instr !== model_mem[3]) begin
      n_fail++;
      $display("FAIL backpressure_release: valid=%b pc=%0d instr=%h, want 1/3/%h",
               instr_valid, instr_pc, instr, model_mem[3]);
    end
  endtask

  task automatic test_jump();
    // Continues the run left by test_backpressure; the load during RUN must be ignored.
    tick();
    jmp_en = 1'b1; jmp_addr = 4'd12;
    ld_en = 1'b1; ld_addr = 4'd12; ld_data = ~model_mem[12];
    tick();
    jmp_en = 1'b0; ld_en = 1'b0;
    n_tests++;
    if (instr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL jump_clear: valid=%b, want 0", instr_valid);
    end
    tick();
    n_tests++;
    if (instr_valid !== 1'b1 || instr_pc !== 4'd12 || instr !== model_mem[12]) begin
      n_fail++;
      $display("FAIL jump_target: valid=%b pc=%0d instr=%h, want 1/12/%h",
               instr_valid, instr_pc, instr, model_mem[12]);
    end
    start = 1'b1; jmp_en = 1'b1; jmp_addr = 4'd9;
    tick();
    start = 1'b0; jmp_en = 1'b0;
    tick();
    n_tests++;
    if (instr_valid !== 1'b1 || instr_pc !== 4'd0) begin
      n_fail++;
      $display("FAIL start_over_jump: valid=%b pc=%0d, want 1/0", instr_valid, instr_pc);
    end
    do_reset();
    jmp_en = 1'b1; jmp_addr = 4'd7;
    tick();
    jmp_en = 1'b0;
    start_run();
    ready = 1'b1;
    tick();
    n_tests++;
    if (instr_valid !== 1'b1 || instr_pc !== 4'd0 || instr !== model_mem[0]) begin
      n_fail++;
      $display("FAIL jump_in_idle: valid=%b pc=%0d instr=%h, want 1/0/%h",
               instr_valid, instr_pc, instr, model_mem[0]);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    start_run();
    ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      tick();
      n_tests++;
      if (instr_valid !== 1'b1 || instr_pc !== AW'(i % DEPTH) || instr !== model_mem[i % DEPTH]) begin
        n_fail++;
        $display("FAIL wrap[%0d]: valid=%b pc=%0d instr=%h, want 1/%0d/%h",
                 i, instr_valid, instr_pc, instr, i % DEPTH, model_mem[i % DEPTH]);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_tests++;
    if ({instr, instr_pc, instr_valid, halted, parity_err} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: instr=%h pc=%0d valid=%b halted=%b perr=%b, want all 0",
               instr, instr_pc, instr_valid, halted, parity_err);
    end
    tick();
    rst = 1'b0;
    tick(); tick();
    n_tests++;
    if (instr_valid !== 1'b0 || halted !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_to_idle: valid=%b halted=%b, want 0/0", instr_valid, halted);
    end
    start_run();
    for (int i = 0; i < 4; i++) begin
      tick();
      n_tests++;
      if (instr_valid !== 1'b1 || instr_pc !== AW'(i) || instr !== model_mem[i]) begin
        n_fail++;
        $display("FAIL mem_kept[%0d]: valid=%b pc=%0d instr=%h, want 1/%0d/%h",
                 i, instr_valid, instr_pc, instr, i, model_mem[i]);
      end
    end
  endtask

  task automatic test_random();
    logic          pv;
    logic [AW-1:0] ppc, exp_addr, ja;
    logic [DW-1:0] pinstr;
    logic          r, j;
    do_reset();
    load_random_program();
    start_run();
    exp_addr = '0;
    for (int c = 0; c < 300; c++) begin
      pv = instr_valid; ppc = instr_pc; pinstr = instr;
      r  = 1'($urandom_range(0, 1));
      j  = ($urandom_range(0, 9) == 0);
      ja = AW'($urandom);
      ready = r; jmp_en = j; jmp_addr = ja;
      tick();
      n_tests++;
      if (j) begin
        if (instr_valid !== 1'b0 || parity_err !== 1'b0) begin
          n_fail++;
          $display("FAIL rand_jump[%0d]: valid=%b perr=%b, want 0/0", c, instr_valid, parity_err);
        end
        exp_addr = ja;
      end else if (pv && !r) begin
        if (instr_valid !== 1'b1 || instr_pc !== ppc || instr !== pinstr || parity_err !== 1'b0) begin
          n_fail++;
          $display("FAIL rand_hold[%0d]: valid=%b pc=%0d instr=%h perr=%b, want 1/%0d/%h/0",
                   c, instr_valid, instr_pc, instr, parity_err, ppc, pinstr);
        end
      end else begin
        if (instr_valid !== 1'b1 || instr_pc !== exp_addr || instr !== model_mem[exp_addr] ||
            parity_err !== 1'b0) begin
          n_fail++;
          $display("FAIL rand_fetch[%0d]: valid=%b pc=%0d instr=%h perr=%b, want 1/%0d/%h/0",
                   c, instr_valid, instr_pc, instr, parity_err, exp_addr, model_mem[exp_addr]);
        end
        exp_addr = exp_addr + 4'd1;
      end
    end
    ready = 1'b0; jmp_en = 1'b0;
  endtask

`ifdef INSTR_FETCH_ROM_PARITY_EN
  task automatic test_parity();
    do_reset();
    dut.u_mem.mem_q[5][0] = ~dut.u_mem.mem_q[5][0];
    start_run();
    ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_tests++;
      if (parity_err !== (i == 5) || instr_pc !== AW'(i)) begin
        n_fail++;
        $display("FAIL parity_detect[%0d]: perr=%b pc=%0d, want %b/%0d", i, parity_err, instr_pc, (i == 5), i);
      end
    end
    ready = 1'b0;
    tick(); tick();
    n_tests++;
    if (parity_err !== 1'b1) begin
      n_fail++;
      $display("FAIL parity_sticky: perr=%b, want 1", parity_err);
    end
    start_run();
    n_tests++;
    if (parity_err !== 1'b0) begin
      n_fail++;
      $display("FAIL parity_clear: perr=%b, want 0", parity_err);
    end
    do_reset();
    dut.u_mem.mem_q[5][0] = ~dut.u_mem.mem_q[5][0];
  endtask
`endif

  initial begin
    test_reset();
    test_program();
    test_backpressure();
    test_jump();
    test_wrap();
    test_reset_mid_run();
    test_random();
`ifdef INSTR_FETCH_ROM_PARITY_EN
    test_parity();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
